// File: rtl/eventually_pkg.sv
// rtl/eventually_pkg.sv - shared state encoding and width helper for the eventually responder
package eventually_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ACK   = 2'd2,
    BAD   = 2'd3
  } state_t;

  // Never returns less than 1 so a counter with a single legal value still has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stall_budget.sv
// rtl/stall_budget.sv - saturating per-request stall allowance
module stall_budget
  import eventually_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic b,
  input  logic en,
  output logic stall
);

  localparam int STALL_W = clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] LIMIT = STALL_W'(MAX_STALL);

  logic [STALL_W-1:0] stall_cnt;

  // Once the budget is spent, b is ignored and the request is forced forward.
  assign stall = b & en & (stall_cnt < LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/eventually_responder.sv
// rtl/eventually_responder.sv - 4-phase responder whose ack cannot be masked by stalls
module eventually_responder
  import eventually_pkg::*;
#(
  parameter int DELAY     = 3,
  parameter int MAX_STALL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic y,
  output logic busy
);

  localparam int CNT_W = clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             stall;
  logic             y_next;
  logic             busy_next;

  stall_budget #(
    .MAX_STALL(MAX_STALL)
  ) u_stall_budget (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .b    (b),
    .en   (state == COUNT),
    .stall(stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      y     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      y     <= y_next;
      busy  <= busy_next;
    end
  end

  // a is deliberately ignored in COUNT so an early drop still completes the handshake.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (a) begin
          state_next = COUNT;
          cnt_next   = '0;
        end
      end
      COUNT: begin
        if (!stall) begin
          if (cnt == CNT_LAST) begin
            state_next = ACK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      ACK: begin
        if (!a) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    y_next    = (state_next == ACK);
    busy_next = (state_next == COUNT) || (state_next == ACK);
  end

endmodule

// File: tb/tb_eventually_responder.sv
// tb/tb_eventually_responder.sv - directed self-checking bench for eventually_responder
module tb_eventually_responder;

  localparam int DELAY     = 3;
  localparam int MAX_STALL = 4;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic a    = 1'b0;
  logic b    = 1'b0;
  logic y;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  eventually_responder #(
    .DELAY    (DELAY),
    .MAX_STALL(MAX_STALL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .y   (y),
    .busy(busy)
  );

  // Reference: a request owes DELAY units of work and may defer up to MAX_STALL edges.
  int m_phase  = 0;  // 0 idle, 1 working, 2 acknowledging
  int m_left   = 0;
  int m_budget = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (a) begin
          m_phase  = 1;
          m_left   = DELAY;
          m_budget = MAX_STALL;
        end
        1: begin
          if (b && m_budget > 0) begin
            m_budget = m_budget - 1;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 2;
          end
        end
        default: if (!a) m_phase = 0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_y", {31'd0, y}, {31'd0, (m_phase == 2)});
      check("model_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
    end
  end

  task automatic drive(input logic ra, input logic rb, input logic rr);
    a   = ra;
    b   = rb;
    rst = rr;
    @(posedge clk);
    #1;
  endtask

  // Capture at edge 0, then count edges until y appears; b is high on edges 1..b_cycles.
  task automatic wait_ack(input int b_cycles, input int exp_edge, input string name);
    int n;
    n = 0;
    drive(1'b1, 1'b0, 1'b0);
    check({name, "_busy_capture"}, {31'd0, busy}, 32'd1);
    while (!y && n < 20) begin
      n++;
      drive(1'b1, (n <= b_cycles), 1'b0);
    end
    check({name, "_ack_edge"}, n, exp_edge);
  endtask

  task automatic release_a(input string name);
    drive(1'b0, 1'b0, 1'b0);
    check({name, "_y_drop"}, {31'd0, y}, 32'd0);
    check({name, "_busy_drop"}, {31'd0, busy}, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    check_en = 1'b1;
    check("reset_y", {31'd0, y}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    drive(1'b0, 1'b0, 1'b0);

    wait_ack(0, 3, "basic");
    drive(1'b1, 1'b0, 1'b0);
    check("basic_hold", {31'd0, y}, 32'd1);
    release_a("basic");

    wait_ack(2, 5, "stall2");
    release_a("stall2");

    wait_ack(99, 7, "stall_all");
    release_a("stall_all");

    wait_ack(2, 5, "budget_refill");
    release_a("budget_refill");

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("early_e2_y", {31'd0, y}, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("early_e3_y", {31'd0, y}, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    check("early_e4_y", {31'd0, y}, 32'd0);
    check("early_e4_busy", {31'd0, busy}, 32'd0);

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    check("rst_mid_y", {31'd0, y}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (8) drive(1'b0, 1'b0, 1'b0);
    check("rst_after_busy", {31'd0, busy}, 32'd0);

    wait_ack(0, 3, "b2b_first");
    drive(1'b0, 1'b0, 1'b0);
    check("b2b_idle_busy", {31'd0, busy}, 32'd0);
    wait_ack(0, 3, "b2b_second");
    release_a("b2b_second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
